// File: rtl/cordic_iter_seq.sv
// CORDIC iteration sequencer: produces the per-iteration shift/ROM address and
// framing flags for circular or hyperbolic CORDIC, with hyperbolic repeats.
module cordic_iter_seq #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [WIDTH-1:0] niter,
    output logic [WIDTH-1:0] addr,
    output logic             valid,
    output logic             first,
    output logic             last,
    output logic             rpt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ADDR_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    state_t           state_r, state_s;
    logic [WIDTH-1:0] addr_r, addr_s;
    logic [WIDTH-1:0] step_r, step_s;
    logic [WIDTH-1:0] niter_r, niter_s;
    logic             mode_r, mode_s;
    logic             rpt_r, rpt_s;
    logic             last_s;
    logic             accept_s;

    // Hyperbolic CORDIC must repeat these indices to converge; values at or
    // above 2^WIDTH can never match because addr cannot hold them.
    function automatic logic is_repeat_addr(input logic [WIDTH-1:0] a);
        logic [31:0] v;
        v = 32'(a);
        return (v == 32'd4) || (v == 32'd13) || (v == 32'd40);
    endfunction

    assign last_s   = (state_r == RUN) && ((step_r + ONE) == niter_r);
    assign accept_s = start && !abort && ((state_r == IDLE) || (state_r == DONE));

    // State register; reset overrides enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            addr_r  <= ZERO;
            step_r  <= ZERO;
            niter_r <= ZERO;
            mode_r  <= 1'b0;
            rpt_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            step_r  <= step_s;
            niter_r <= niter_s;
            mode_r  <= mode_s;
            rpt_r   <= rpt_s;
        end
    end

    // Next-state logic: abort beats start, and start is only honoured in IDLE/DONE.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        step_s  = step_r;
        niter_s = niter_r;
        mode_s  = mode_r;
        rpt_s   = rpt_r;
        if (!enable) begin
            state_s = state_r;
        end else if (accept_s) begin
            niter_s = niter;
            mode_s  = mode;
            step_s  = ZERO;
            rpt_s   = 1'b0;
            if (niter != ZERO) begin
                state_s = RUN;
                addr_s  = mode ? ONE : ZERO;
            end else begin
                state_s = DONE;
                addr_s  = ZERO;
            end
        end else if (abort || (state_r == IDLE) || (state_r == DONE)) begin
            state_s = IDLE;
            addr_s  = ZERO;
            step_s  = ZERO;
            rpt_s   = 1'b0;
        end else if (state_r == RUN) begin
            if (last_s) begin
                state_s = DONE;
            end else begin
                step_s = step_r + ONE;
                if (mode_r && is_repeat_addr(addr_r) && !rpt_r) begin
                    rpt_s = 1'b1;
                end else begin
                    rpt_s  = 1'b0;
                    addr_s = (addr_r == ADDR_MAX) ? addr_r : (addr_r + ONE);
                end
            end
        end else begin
            state_s = IDLE;
            addr_s  = ZERO;
            step_s  = ZERO;
            rpt_s   = 1'b0;
        end
    end

    assign addr  = addr_r;
    assign valid = (state_r == RUN);
    assign first = (state_r == RUN) && (step_r == ZERO);
    assign last  = last_s;
    assign rpt   = (state_r == RUN) && rpt_r;
    assign busy  = (state_r == RUN) || (state_r == DONE);
    assign done  = (state_r == DONE);

endmodule
